// File: rtl/cmos_stream_if.sv
// Bundle of the CMOS RAM initiator port plus the dump (tx) and load (rx) byte streams.
interface cmos_stream_if #(
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned AW = $clog2(DEPTH);

  // RAM port (engine is the initiator)
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wdata;
  logic [3:0]    ram_rdata;

  // Dump byte stream
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  // Load byte stream
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport master (
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );

  modport slave (
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );
endinterface

// File: rtl/cmos_stream.sv
// Bulk dump/load engine for the nibble-wide CMOS RAM: packs nibble pairs into bytes
// (low nibble at the even address) and streams the whole RAM in or out.
module cmos_stream #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_dump,
  input  logic          start_load,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  cmos_stream_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned KW = AW - 1;
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH / 2 - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_SEND,
    S_RX_WAIT,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    lo_q, lo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cs_q, cs_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    wdata_q, wdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rx_ready_q, rx_ready_d;

  // Next-state, datapath and next-output decode; outputs are registered from state_d
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lo_d      = lo_q;
    rx_byte_d = rx_byte_q;
    tx_data_d = tx_data_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_dump) begin
          state_d = S_RD_LO;
          k_d     = '0;
        end else if (start_load) begin
          state_d = S_RX_WAIT;
          k_d     = '0;
        end
      end
      S_RD_LO: state_d = S_RD_HI;
      S_RD_HI: begin
        // read data of the even address arrives during this state
        lo_d    = bus.ram_rdata;
        state_d = S_CAP;
      end
      S_CAP: begin
        tx_data_d = {bus.ram_rdata, lo_q};
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_RD_LO;
          end
        end
      end
      S_RX_WAIT: begin
        if (bus.rx_valid) begin
          rx_byte_d = bus.rx_data;
          state_d   = S_WR_LO;
        end
      end
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_RX_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition; a write in flight this cycle still commits
    if (abort) begin
      state_d = S_IDLE;
    end

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    cs_d       = (state_d == S_RD_LO) || (state_d == S_RD_HI) ||
                 (state_d == S_WR_LO) || (state_d == S_WR_HI);
    we_d       = (state_d == S_WR_LO) || (state_d == S_WR_HI);
    addr_d     = {k_d, (state_d == S_RD_HI) || (state_d == S_WR_HI)};
    tx_valid_d = (state_d == S_SEND);
    rx_ready_d = (state_d == S_RX_WAIT);

    if (state_d == S_WR_LO) begin
      wdata_d = rx_byte_d[3:0];
    end else if (state_d == S_WR_HI) begin
      wdata_d = rx_byte_d[7:4];
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      lo_q       <= '0;
      rx_byte_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      lo_q       <= lo_d;
      rx_byte_q  <= rx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.ram_cs    = cs_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.rx_ready  = rx_ready_q;

endmodule
